cp0_exc_reg: RTL and testbench

Parametrised coprocessor-0 register block for the OpenMIPS core. It succeeds the plain CP0 file and adds precise-exception state update (EPC/Cause/Status on exception and ERET), a configurable number of hardware interrupt lines, a prescaled Count timer, and Compare-match timer interrupt. It is written from the write-back stage, read combinationally by EX, and fed exception information from MEM. Exception detection and pipeline flush are handled by ctrl.

---
 rtl/cp0_exc_reg.sv | 168 ++++++++++++++++
 tb/tb_cp0_exc_reg.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_reg.sv
// Coprocessor-0 register block: Count/Compare timer, Status, Cause, EPC,
// precise exception and ERET state update, hardware interrupt sampling.
module cp0_exc_reg #(
  parameter int          INT_NUM      = 6,
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [31:0]        data_i,
  input  logic [4:0]         raddr_i,
  input  logic [INT_NUM-1:0] int_i,
  input  logic [31:0]        excepttype_i,
  input  logic [31:0]        current_inst_addr_i,
  input  logic               is_in_delayslot_i,
  output logic [31:0]        data_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        config_o,
  output logic [31:0]        prid_o,
  output logic               timer_int_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

  localparam logic [4:0] R_COUNT   = 5'd9;
  localparam logic [4:0] R_COMPARE = 5'd11;
  localparam logic [4:0] R_STATUS  = 5'd12;
  localparam logic [4:0] R_CAUSE   = 5'd13;
  localparam logic [4:0] R_EPC     = 5'd14;
  localparam logic [4:0] R_PRID    = 5'd15;
  localparam logic [4:0] R_CONFIG  = 5'd16;

  localparam logic [31:0] ST_MASK  = 32'hF000FF03;
  localparam logic [31:0] CA_MASK  = 32'h00C00300;
  localparam logic [31:0] ST_RESET = 32'h10000000;
  localparam logic [31:0] T_ERET   = 32'h0000000E;

  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [31:0]   status_q;
  logic [31:0]   cause_q;
  logic [31:0]   epc_q;
  logic [PW-1:0] pre_q;
  logic          timer_q;

  logic [31:0] status_d;
  logic [31:0] cause_d;
  logic [31:0] epc_d;
  logic [4:0]  exc_code;
  logic        exc;
  logic        eret;
  logic        wr_count;
  logic        wr_cmp;
  logic        tick;
  logic        match;

  assign wr_count = we_i && (waddr_i == R_COUNT);
  assign wr_cmp   = we_i && (waddr_i == R_COMPARE);
  assign tick     = (pre_q == PRE_MAX);
  assign match    = (compare_q != 32'd0) && (count_q == compare_q);
  assign eret     = (excepttype_i == T_ERET);
  assign exc      = (excepttype_i != 32'd0) && !eret;

  always_comb begin
    exc_code = 5'h0a;
    case (excepttype_i)
      32'h1:   exc_code = 5'h00;
      32'h8:   exc_code = 5'h08;
      32'ha:   exc_code = 5'h0a;
      32'hc:   exc_code = 5'h0c;
      32'hd:   exc_code = 5'h0d;
      default: exc_code = 5'h0a;
    endcase
  end

  // WB write lands first; the exception then overrides EXL/EPC/BD/ExcCode
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (we_i) begin
      unique case (1'b1)
        waddr_i == R_STATUS: status_d = data_i & ST_MASK;
        waddr_i == R_CAUSE:
          cause_d = (cause_q & ~CA_MASK) | (data_i & CA_MASK);
        waddr_i == R_EPC:    epc_d = data_i;
        default: ;
      endcase
    end
    for (int i = 0; i < INT_NUM; i++) begin
      cause_d[10+i] = int_i[i];
    end
    if (exc) begin
      if (!status_d[1]) begin
        epc_d = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                  : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= ST_RESET;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      pre_q     <= '0;
      timer_q   <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q <= data_i;
        pre_q   <= '0;
      end else begin
        pre_q <= tick ? '0 : pre_q + PW'(1);
        if (tick) count_q <= count_q + 32'd1;
      end
      if (wr_cmp) begin
        compare_q <= data_i;
        timer_q   <= 1'b0;
      end else if (match) begin
        timer_q <= 1'b1;
      end
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (!rst) begin
      case (raddr_i)
        R_COUNT:   data_o = count_q;
        R_COMPARE: data_o = compare_q;
        R_STATUS:  data_o = status_q;
        R_CAUSE:   data_o = cause_q;
        R_EPC:     data_o = epc_q;
        R_PRID:    data_o = PRID_VALUE;
        R_CONFIG:  data_o = CONFIG_VALUE;
        default:   data_o = 32'd0;
      endcase
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_exc_reg.sv
// Bench for cp0_exc_reg: two configurations driven in lockstep and
// compared every cycle against a field-level model of the CP0 rules.
module tb_cp0_exc_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] data;
  logic [4:0]  raddr;
  logic [5:0]  irq;
  logic [31:0] etype;
  logic [31:0] pc;
  logic        ds;

  logic [31:0] rd[2];
  logic [31:0] cnt[2];
  logic [31:0] cmp[2];
  logic [31:0] st[2];
  logic [31:0] ca[2];
  logic [31:0] ep[2];
  logic [31:0] cf[2];
  logic [31:0] pr[2];
  logic        tmr[2];

  int nchk = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cp0_exc_reg #(.INT_NUM(6), .COUNT_DIV(1)) u0 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr),
    .data_i(data), .raddr_i(raddr), .int_i(irq),
    .excepttype_i(etype), .current_inst_addr_i(pc),
    .is_in_delayslot_i(ds), .data_o(rd[0]), .count_o(cnt[0]),
    .compare_o(cmp[0]), .status_o(st[0]), .cause_o(ca[0]),
    .epc_o(ep[0]), .config_o(cf[0]), .prid_o(pr[0]),
    .timer_int_o(tmr[0])
  );

  cp0_exc_reg #(.INT_NUM(3), .COUNT_DIV(2)) u1 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr),
    .data_i(data), .raddr_i(raddr), .int_i(irq[2:0]),
    .excepttype_i(etype), .current_inst_addr_i(pc),
    .is_in_delayslot_i(ds), .data_o(rd[1]), .count_o(cnt[1]),
    .compare_o(cmp[1]), .status_o(st[1]), .cause_o(ca[1]),
    .epc_o(ep[1]), .config_o(cf[1]), .prid_o(pr[1]),
    .timer_int_o(tmr[1])
  );

  // model state, one entry per configuration
  logic [31:0] m_count[2];
  logic [31:0] m_cmp[2];
  logic [31:0] m_epc[2];
  int          m_pre[2];
  logic        m_tim[2];
  logic [3:0]  m_cu[2];
  logic [7:0]  m_im[2];
  logic        m_exl[2];
  logic        m_ie[2];
  logic        m_bd[2];
  logic        m_iv[2];
  logic        m_wp[2];
  logic [1:0]  m_ipsw[2];
  logic [5:0]  m_iphw[2];
  logic [4:0]  m_code[2];

  function automatic logic [31:0] m_status(int k);
    return {m_cu[k], 12'h0, m_im[k], 6'h0, m_exl[k], m_ie[k]};
  endfunction

  function automatic logic [31:0] m_cause(int k);
    return {m_bd[k], 7'h0, m_iv[k], m_wp[k], 6'h0,
            m_iphw[k], m_ipsw[k], 1'b0, m_code[k], 2'b0};
  endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    if (rst) return 32'd0;
    case (a)
      5'd9:    return m_count[k];
      5'd11:   return m_cmp[k];
      5'd12:   return m_status(k);
      5'd13:   return m_cause(k);
      5'd14:   return m_epc[k];
      5'd15:   return 32'h00480102;
      5'd16:   return 32'h00008000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(int k);
    int dv = (k == 1) ? 2 : 1;
    logic [5:0] msk = (k == 1) ? 6'b000111 : 6'b111111;
    logic nt;
    if (rst) begin
      m_count[k] = 0; m_cmp[k] = 0; m_epc[k] = 0;
      m_pre[k] = 0; m_tim[k] = 0;
      m_cu[k] = 4'h1; m_im[k] = 0; m_exl[k] = 0; m_ie[k] = 0;
      m_bd[k] = 0; m_iv[k] = 0; m_wp[k] = 0;
      m_ipsw[k] = 0; m_iphw[k] = 0; m_code[k] = 0;
      return;
    end
    nt = m_tim[k] | (m_cmp[k] != 0 && m_count[k] == m_cmp[k]);
    if (we && waddr == 5'd11) nt = 1'b0;
    m_tim[k] = nt;
    if (we && waddr == 5'd9) begin
      m_count[k] = data;
      m_pre[k] = 0;
    end else if (m_pre[k] == dv - 1) begin
      m_pre[k] = 0;
      m_count[k] = m_count[k] + 1;
    end else begin
      m_pre[k] = m_pre[k] + 1;
    end
    if (we && waddr == 5'd11) m_cmp[k] = data;
    if (we && waddr == 5'd12) begin
      m_cu[k] = data[31:28]; m_im[k] = data[15:8];
      m_exl[k] = data[1];    m_ie[k] = data[0];
    end
    if (we && waddr == 5'd13) begin
      m_iv[k] = data[23]; m_wp[k] = data[22];
      m_ipsw[k] = data[9:8];
    end
    if (we && waddr == 5'd14) m_epc[k] = data;
    m_iphw[k] = irq & msk;
    if (etype == 32'he) begin
      m_exl[k] = 1'b0;
    end else if (etype != 0) begin
      if (!m_exl[k]) begin
        m_epc[k] = ds ? pc - 4 : pc;
        m_bd[k] = ds;
      end
      m_exl[k] = 1'b1;
      case (etype)
        32'h1:   m_code[k] = 5'h00;
        32'h8:   m_code[k] = 5'h08;
        32'hc:   m_code[k] = 5'h0c;
        32'hd:   m_code[k] = 5'h0d;
        default: m_code[k] = 5'h0a;
      endcase
    end
  endtask

  task automatic check(input string nm, input int k,
                       input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s[%0d] got %h expected %h at %0t",
               nm, k, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("count", k, cnt[k], m_count[k]);
        check("compare", k, cmp[k], m_cmp[k]);
        check("status", k, st[k], m_status(k));
        check("cause", k, ca[k], m_cause(k));
        check("epc", k, ep[k], m_epc[k]);
        check("config", k, cf[k], 32'h00008000);
        check("prid", k, pr[k], 32'h00480102);
        check("timer", k, {31'b0, tmr[k]}, {31'b0, m_tim[k]});
        check("data_o", k, rd[k], m_read(k, raddr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
  endtask

  task automatic idle();
    we = 0; waddr = 0; data = 0; etype = 0; pc = 0; ds = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; data = d;
  endtask

  localparam logic [31:0] EXC_LIST[5] = '{1, 8, 10, 12, 13};

  initial begin
    logic [31:0] c0_exp[4];
    logic [31:0] c1_exp[4];
    int r;
    c0_exp = '{1, 2, 3, 4};
    c1_exp = '{0, 1, 1, 2};
    rst = 1; raddr = 5'd15; irq = 0;
    idle();
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_data_o", 0, rd[0], 32'd0);
    check("rst_status", 0, st[0], 32'h10000000);
    check("rst_prid", 1, pr[1], 32'h00480102);
    check("rst_count", 1, cnt[1], 32'd0);

    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cnt_div1", 0, cnt[0], c0_exp[i]);
      check("cnt_div2", 1, cnt[1], c1_exp[i]);
    end

    // compare match on the DIV=1 instance
    wr(5'd9, 32'd0);
    tick();
    wr(5'd11, 32'd5);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    check("cnt_at5", 0, cnt[0], 32'd5);
    check("tmr_pre", 0, {31'b0, tmr[0]}, 32'd0);
    tick();
    check("tmr_set", 0, {31'b0, tmr[0]}, 32'd1);
    tick();
    check("tmr_hold", 0, {31'b0, tmr[0]}, 32'd1);
    wr(5'd11, 32'h20);
    tick();
    idle();
    check("tmr_clr", 0, {31'b0, tmr[0]}, 32'd0);

    wr(5'd9, 32'hFFFFFFFE);
    tick();
    idle();
    check("wrap_a", 0, cnt[0], 32'hFFFFFFFE);
    tick();
    check("wrap_b", 0, cnt[0], 32'hFFFFFFFF);
    tick();
    check("wrap_c", 0, cnt[0], 32'd0);

    // syscall in delay slot, then nested overflow, then eret
    etype = 32'h8; pc = 32'h100; ds = 1;
    tick();
    idle();
    check("sys_epc", 0, ep[0], 32'hFC);
    check("sys_bd", 0, {31'b0, ca[0][31]}, 32'd1);
    check("sys_exl", 0, {31'b0, st[0][1]}, 32'd1);
    check("sys_code", 0, {27'b0, ca[0][6:2]}, 32'h8);
    etype = 32'hc; pc = 32'h200; ds = 0;
    tick();
    idle();
    check("ovf_epc", 0, ep[0], 32'hFC);
    check("ovf_code", 0, {27'b0, ca[0][6:2]}, 32'hc);
    etype = 32'he;
    tick();
    idle();
    check("eret_st", 0, st[0], 32'h10000000);

    // MTC0 Status alongside an interrupt exception
    wr(5'd12, 32'h0000FF01);
    etype = 32'h1; pc = 32'h300;
    tick();
    idle();
    check("mtc0_exc_st", 0, st[0], 32'h0000FF03);
    check("mtc0_exc_code", 0, {27'b0, ca[0][6:2]}, 32'h0);
    etype = 32'he;
    tick();
    idle();

    // interrupt sampling and Cause write masking
    irq = 6'b000101;
    tick();
    check("ip_n3", 1, {26'b0, ca[1][15:10]}, 32'b000101);
    wr(5'd13, 32'hFFFFFFFF);
    tick();
    idle();
    check("cause_wr", 1, ca[1] & 32'h7FFFFF83, 32'h00C01700);
    irq = 6'b111010;
    tick();
    check("ip_n3b", 1, {26'b0, ca[1][15:10]}, 32'b000010);
    check("ip_n6b", 0, {26'b0, ca[0][15:10]}, 32'b111010);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) waddr = 5'($urandom);
      else waddr = 5'(9 + $urandom_range(0, 7));
      r = $urandom_range(0, 5);
      if (r == 0) data = m_cmp[0] - $urandom_range(0, 3);
      else if (r == 1) data = m_count[0] + $urandom_range(0, 3);
      else if (r == 2) data = 32'd0;
      else data = $urandom;
      raddr = 5'($urandom);
      irq = 6'($urandom);
      pc = $urandom;
      ds = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5) etype = 0;
      else if (r == 6) etype = EXC_LIST[$urandom_range(0, 4)];
      else if (r == 7) etype = 32'he;
      else if (r == 8) etype = $urandom;
      else etype = $urandom_range(0, 15);
      tick();
    end
    rst = 0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
